// File: rtl/mag_peak_search.sv
// Timing peak search: accumulates NSYM windows of WIN_LEN magnitude samples per position
// and reports the earliest position holding the largest accumulated magnitude.
module mag_peak_search #(
    parameter int WIN_LEN = 64,
    parameter int NSYM    = 4,
    parameter int MAG_W   = 16,
    parameter int IDX_W   = $clog2(WIN_LEN),
    parameter int ACC_W   = MAG_W + $clog2(NSYM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mag_valid,
    input  logic [MAG_W-1:0] mag_in,
    input  logic [ACC_W-1:0] thresh,
    output logic             busy,
    output logic             peak_valid,
    output logic             peak_found,
    output logic [IDX_W-1:0] peak_idx,
    output logic [ACC_W-1:0] peak_acc
);

    localparam int WIN_W      = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int POS_LAST_I = WIN_LEN - 1;
    localparam int WIN_LAST_I = (NSYM > 1) ? NSYM - 2 : 0;
    localparam logic [IDX_W-1:0] POS_LAST = POS_LAST_I[IDX_W-1:0];
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_LAST_I[WIN_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_LAST   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // With a single window the first pass is already the deciding one.
    localparam state_t ST_ARM = (NSYM > 1) ? ST_ACC : ST_LAST;

    state_t           state_r;
    state_t           state_next;
    logic             clear_s;
    logic             acc_step_s;
    logic             last_step_s;

    logic [ACC_W-1:0] acc_r [WIN_LEN];
    logic [IDX_W-1:0] pos_r;
    logic [WIN_W-1:0] win_r;
    logic [ACC_W-1:0] max_acc_r;
    logic [IDX_W-1:0] max_idx_r;
    logic [ACC_W-1:0] thr_r;

    logic [ACC_W-1:0] sum_s;
    logic             take_s;

    assign sum_s  = acc_r[pos_r] + ACC_W'(mag_in);
    // Position 0 always seeds the running max; strict compare keeps the earliest index on ties.
    assign take_s = (pos_r == {IDX_W{1'b0}}) || (sum_s > max_acc_r);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state decode and datapath strobes; start takes priority over any sample.
    always_comb begin
        state_next  = state_r;
        clear_s     = 1'b0;
        acc_step_s  = 1'b0;
        last_step_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clear_s    = 1'b1;
                    state_next = ST_ARM;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (start) begin
                    clear_s    = 1'b1;
                    state_next = ST_ARM;
                end else if (mag_valid) begin
                    acc_step_s = 1'b1;
                    if ((pos_r == POS_LAST) && (win_r == WIN_LAST)) begin
                        state_next = ST_LAST;
                    end else begin
                        state_next = ST_ACC;
                    end
                end else begin
                    state_next = ST_ACC;
                end
            end
            ST_LAST: begin
                if (start) begin
                    clear_s    = 1'b1;
                    state_next = ST_ARM;
                end else if (mag_valid) begin
                    last_step_s = 1'b1;
                    if (pos_r == POS_LAST) begin
                        state_next = ST_REPORT;
                    end else begin
                        state_next = ST_LAST;
                    end
                end else begin
                    state_next = ST_LAST;
                end
            end
            ST_REPORT: begin
                if (start) begin
                    clear_s    = 1'b1;
                    state_next = ST_ARM;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Accumulator array, position/window counters, running max and latched threshold.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
            pos_r     <= {IDX_W{1'b0}};
            win_r     <= {WIN_W{1'b0}};
            max_acc_r <= {ACC_W{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
            thr_r     <= rst ? {ACC_W{1'b0}} : thresh;
        end else if (acc_step_s) begin
            acc_r[pos_r] <= sum_s;
            pos_r        <= pos_r + IDX_W'(1);
            if (pos_r == POS_LAST) begin
                win_r <= win_r + WIN_W'(1);
            end else begin
                win_r <= win_r;
            end
        end else if (last_step_s) begin
            pos_r <= pos_r + IDX_W'(1);
            if (take_s) begin
                max_acc_r <= sum_s;
                max_idx_r <= pos_r;
            end else begin
                max_acc_r <= max_acc_r;
                max_idx_r <= max_idx_r;
            end
        end else begin
            pos_r <= pos_r;
        end
    end

    // Registered status: busy mirrors the upcoming state, results load while in REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            peak_valid <= 1'b0;
            peak_found <= 1'b0;
            peak_idx   <= {IDX_W{1'b0}};
            peak_acc   <= {ACC_W{1'b0}};
        end else begin
            busy <= (state_next == ST_ACC) || (state_next == ST_LAST);
            if (state_r == ST_REPORT) begin
                peak_valid <= 1'b1;
                peak_idx   <= max_idx_r;
                peak_acc   <= max_acc_r;
                peak_found <= (max_acc_r >= thr_r);
            end else begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule
